inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq.sv | 154 +++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
//   Iterative AES inverse-SubBytes engine. LANES combinational inverse S-boxes
//   are reused over the 16 bytes of one 128-bit state, LANES bytes per cycle,
//   so a state takes N = 16/LANES cycles in SUB. One state is in flight at a
//   time; a new one may be accepted in the same cycle the result is consumed.
//
// Parameters
//   LANES      inverse S-box instances (1, 2, 4, 8 or 16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clear      synchronous abort back to IDLE (src/res untouched)
//   in_valid   data_in is valid
//   in_ready   block accepts data_in this cycle (combinational on out_ready)
//   data_in    state to transform, byte k = data_in[8k+7:8k]
//   out_valid  data_out holds a completed result
//   out_ready  downstream consumes data_out
//   data_out   result, byte k = InvSBox(source byte k)
//   busy       high while in SUB or DONE
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   src_q;
  logic [127:0]   res_q;
  logic [127:0]   res_d;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    // NOTE: blocking assignments are correct here: this is combinational
    // scratch math inside a function, not clocked state.
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);   // a^(2^i)
      r = gf_mul(r, p);   // accumulates a^(2+4+...+128)
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map (rotl 1, 3, 6 plus 0x05), then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Lane j rewrites byte cnt*LANES+j of res; all other bytes hold.
  always_comb begin : lane_mux
    logic [3:0] idx;
    // NOTE: defaulting every variable first keeps this block free of latches.
    res_d = res_q;
    idx   = '0;
    for (int j = 0; j < LANES; j++) begin
      idx = 4'(int'(cnt_q) * LANES + j);
      res_d[{idx, 3'b000} +: 8] = inv_sbox(src_q[{idx, 3'b000} +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: src/res are plain registers (not a RAM), so they are reset to give
    // a defined data_out of zero out of reset.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else if (clear) begin
      // Abort drops the state in flight but leaves src/res as they are.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q   <= data_in;
            cnt_q   <= '0;
            state_q <= SUB;
          end
        end
        SUB: begin
          res_q <= res_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              // Back-to-back acceptance removes the IDLE bubble.
              src_q   <= data_in;
              cnt_q   <= '0;
              state_q <= SUB;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = res_q;
  assign in_ready  = !clear &&
                     ((state_q == IDLE) || ((state_q == DONE) && out_ready));

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
//   Bench for inv_sub_bytes_seq. Five instances cover LANES = 4, 1, 2, 8, 16;
//   instance 0 (LANES=4) carries the reset, backpressure and abort scenarios.
//   Expected results come from an inverse S-box table derived here from the
//   forward AES S-box definition.
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

  localparam int NDUT = 5;
  localparam int LANES_TAB [NDUT] = '{4, 1, 2, 8, 16};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         clear     [NDUT];
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic         busy      [NDUT];
  logic [127:0] data_in   [NDUT];
  logic [127:0] data_out  [NDUT];

  int checks   = 0;
  int failures = 0;

  logic [7:0] inv_tab [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(LANES_TAB[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x   = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) acc = acc ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // Forward S-box by brute-force inverse plus affine map, then invert the table.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] ix;
      logic [7:0] s;
      ix = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) ix = 8'(y);
      s = ix ^ rotl8(ix, 1) ^ rotl8(ix, 2) ^ rotl8(ix, 3) ^ rotl8(ix, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[s[8*k +: 8]];
    return r;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input int d, input logic [127:0] data);
    in_valid[d] = 1'b1;
    data_in[d]  = data;
    #1;
    check($sformatf("accept_ready_d%0d", d), in_ready[d], 1'b1);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid, bounded.
  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rand_run(input int d, input int count, input int max_cycles);
    logic [127:0] q[$];
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic accepted;
    in_valid[d] = 1'b0;
    while (recv < count && cyc < max_cycles) begin
      accepted = 1'b0;
      if (!in_valid[d] && sent < count && $urandom_range(0, 3) != 0) begin
        in_valid[d] = 1'b1;
        data_in[d]  = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready[d] = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(ref_state(data_in[d]));
        sent++;
        accepted = 1'b1;
      end
      if (out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) check($sformatf("rand_spurious_d%0d", d), out_valid[d], 1'b0);
        else               check($sformatf("rand_data_d%0d", d), data_out[d], q.pop_front());
        recv++;
      end
      @(negedge clk);
      cyc++;
      if (accepted) in_valid[d] = 1'b0;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    check($sformatf("rand_count_d%0d", d), recv, count);
    check($sformatf("rand_left_d%0d", d), q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] kv_in, kv_exp, a, b, c, z, e, exp_v;
    int lat;
    logic saw_valid;

    kv_in  = {{12{8'h63}}, 8'hff, 8'h00, 8'h7c, 8'h63};
    kv_exp = {{12{8'h00}}, 8'h7d, 8'h52, 8'h01, 8'h00};

    for (int d = 0; d < NDUT; d++) begin
      clear[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      data_in[d]   = '0;
    end
    rst = 1'b1;
    build_tables();
    repeat (2) @(negedge clk);

    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready_d%0d", d),  in_ready[d],  1'b1);
      check($sformatf("rst_out_valid_d%0d", d), out_valid[d], 1'b0);
      check($sformatf("rst_busy_d%0d", d),      busy[d],      1'b0);
      check($sformatf("rst_data_out_d%0d", d),  data_out[d],  128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single transform of the all-zero state.
    send(0, 128'h0);
    check("zero_busy", busy[0], 1'b1);
    wait_out(0, lat);
    check("zero_lat", lat, 4);
    check("zero_data", data_out[0], {16{8'h52}});
    @(negedge clk);

    // Known vector on every lane count.
    for (int d = 0; d < NDUT; d++) begin
      send(d, kv_in);
      wait_out(d, lat);
      check($sformatf("kv_lat_L%0d", LANES_TAB[d]), lat, 16 / LANES_TAB[d]);
      check($sformatf("kv_data_L%0d", LANES_TAB[d]), data_out[d], kv_exp);
      check($sformatf("kv_model_L%0d", LANES_TAB[d]), data_out[d], ref_state(kv_in));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of SUB.
    send(0, 128'h0123456789abcdeffedcba9876543210);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid[0], 1'b0);
    check("midrst_data_out",  data_out[0],  128'h0);
    check("midrst_in_ready",  in_ready[0],  1'b1);
    check("midrst_busy",      busy[0],      1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0]) saw_valid = 1'b1;
    end
    check("midrst_no_completion", saw_valid, 1'b0);

    // Backpressure, then back-to-back acceptance on release.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    z = {$urandom, $urandom, $urandom, $urandom};
    out_ready[0] = 1'b0;
    send(0, a);
    wait_out(0, lat);
    check("bp_lat", lat, 4);
    in_valid[0] = 1'b1;
    data_in[0]  = z;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid[0], 1'b1);
      check("bp_data_hold", data_out[0],  ref_state(a));
      check("bp_in_ready",  in_ready[0],  1'b0);
    end
    out_ready[0] = 1'b1;
    data_in[0]   = b;
    #1;
    check("b2b_in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("b2b_out_valid_drop", out_valid[0], 1'b0);
    check("b2b_busy", busy[0], 1'b1);
    wait_out(0, lat);
    check("b2b_lat", lat, 4);
    check("b2b_data", data_out[0], ref_state(b));
    @(negedge clk);

    // Abort on the second SUB cycle: only bytes 0..3 were rewritten.
    c = {$urandom, $urandom, $urandom, $urandom};
    send(0, c);
    @(negedge clk);
    clear[0] = 1'b1;
    #1;
    check("abort_in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    clear[0] = 1'b0;
    check("abort_idle", busy[0], 1'b0);
    check("abort_out_valid", out_valid[0], 1'b0);
    exp_v = ref_state(b);
    exp_v[31:0] = ref_state(c) >> 0;
    check("abort_res_partial", data_out[0], exp_v);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0]) saw_valid = 1'b1;
    end
    check("abort_no_completion", saw_valid, 1'b0);

    // clear together with in_valid in IDLE: not accepted.
    clear[0]    = 1'b1;
    in_valid[0] = 1'b1;
    data_in[0]  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("clear_idle_in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check("clear_idle_not_captured", busy[0], 1'b0);
    @(negedge clk);
    e = {$urandom, $urandom, $urandom, $urandom};
    send(0, e);
    wait_out(0, lat);
    check("post_clear_lat", lat, 4);
    check("post_clear_data", data_out[0], ref_state(e));
    @(negedge clk);

    // Random regression with stalls.
    rand_run(0, 1000, 30000);
    for (int d = 1; d < NDUT; d++) rand_run(d, 40, 5000);
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (out_valid[d]) saw_valid = 1'b1;
    end
    check("rand_no_extra_output", saw_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
